// File: rtl/zap_mac_sequencer.sv
// Multi-cycle MAC sequencer: 33x9 partial products over four cycles,
// then accumulate, with a one-entry result cache for split long multiplies.
module zap_mac_sequencer #(
  parameter int CHUNK_W = 8,
  parameter int RES_W   = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic        i_high,
  input  logic [31:0] i_rm,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rn,
  input  logic [31:0] i_rh,
  output logic [31:0] o_rd,
  output logic        o_busy
);

  localparam int NUM_CHUNKS = 32 / CHUNK_W;
  localparam logic [1:0] LAST = 2'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ACC
  } state_t;

  state_t             state;
  logic [1:0]         cnt;
  logic [RES_W-1:0]   acc;
  logic [RES_W-1:0]   cache;
  logic               cache_valid;
  logic [128:0]       op_tag;
  logic [128:0]       cache_tag;

  logic [128:0]       tag;
  logic               hit;
  logic               flush;

  logic               op_signed;
  logic [31:0]        op_rm;
  logic [31:0]        op_rs;
  logic [31:0]        op_rn;
  logic [31:0]        op_rh;

  logic [CHUNK_W-1:0] rs_chunk;
  logic signed [32:0] rm_ext;
  logic signed [8:0]  chunk;
  logic signed [41:0] pp;
  logic [RES_W-1:0]   addend;

  assign tag   = {i_signed, i_rm, i_rs, i_rn, i_rh};
  assign hit   = cache_valid && (tag == cache_tag);
  assign o_busy = i_start && !hit;
  assign o_rd  = i_high ? cache[RES_W-1:32] : cache[31:0];

  // A stall outranks the ALU clear but not the writeback clear.
  assign flush = i_reset || i_clear_from_writeback ||
                 (i_clear_from_alu && !i_data_stall);

  assign {op_signed, op_rm, op_rs, op_rn, op_rh} = op_tag;

  assign rs_chunk = op_rs[cnt*CHUNK_W +: CHUNK_W];
  assign rm_ext   = {op_signed & op_rm[31], op_rm};
  assign chunk    = {op_signed && (cnt == LAST) && rs_chunk[7], rs_chunk};
  assign pp       = rm_ext * chunk;
  assign addend   = {{(RES_W-42){pp[41]}}, pp} << (cnt*CHUNK_W);

  always_ff @(posedge i_clk) begin
    if (flush) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      cache       <= '0;
      cache_valid <= 1'b0;
      op_tag      <= '0;
      cache_tag   <= '0;
    end else if (!i_data_stall) begin
      unique case (state)
        IDLE: begin
          if (i_start && !hit) begin
            op_tag <= tag;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          acc <= acc + addend;
          cnt <= cnt + 2'd1;
          if (cnt == LAST) state <= ACC;
        end
        ACC: begin
          cache       <= acc + {op_rh, op_rn};
          cache_valid <= 1'b1;
          cache_tag   <= op_tag;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/zap_mac_sequencer.md
Name: zap_mac_sequencer

Overview:
Multi-cycle controller for the shift-stage multiply-accumulate resource. It sequences a 33x9-bit partial-product datapath over four cycles, then adds the 64-bit accumulator. It caches the 64-bit result so the split long-multiply ops (low word, then high word) compute only once. It drives the stall seen by the shift stage and obeys the pipeline's clear and stall priorities.

Parameters:
CHUNK_W, 8, rs bits consumed per multiply cycle (fixed; NUM_CHUNKS = 32/CHUNK_W = 4)
RES_W, 64, width of product/accumulate result

Ports:
i_clk  in  1  clock
i_reset  in  1  reset; synchronous, active-high
i_clear_from_writeback  in  1  flush, highest priority
i_data_stall  in  1  freeze all state
i_clear_from_alu  in  1  flush, lowest priority
i_start  in  1  multiply op present in shift stage with condition satisfied
i_signed  in  1  1 = signed (SMLAL*), 0 = unsigned (UMLAL*)
i_high  in  1  1 = request result[63:32], 0 = result[31:0]
i_rm  in  32  multiplicand
i_rs  in  32  multiplier
i_rn  in  32  accumulator low word
i_rh  in  32  accumulator high word
o_rd  out  32  selected word of the cached result (combinational)
o_busy  out  1  stall request to shift stage (combinational)

Behaviour:
- Priority each cycle: i_reset > i_clear_from_writeback > i_data_stall > i_clear_from_alu > normal.
- Reset, either clear: state=IDLE, cnt=0, acc=0, cache_valid=0, cache result=0. A clear mid-operation aborts it; no partial result is cached.
- i_data_stall with no higher-priority event: state, cnt, acc, tag and cache are all held.
- Tag = {i_signed, i_rm, i_rs, i_rn, i_rh}. hit = cache_valid && tag == stored tag.
- o_busy = i_start && !hit.
- o_rd = i_high ? cache[63:32] : cache[31:0]. It is valid whenever hit; otherwise don't-care. It is 0 after reset.
- IDLE:
  - i_start && !hit: latch the tag, acc=0, cnt=0, go to MUL.
  - Otherwise stay.
- MUL (4 cycles, cnt 0..3):
  - rm_ext = 33-bit i_rm, sign-extended if signed, else zero-extended.
  - chunk_k = rs[8k+7:8k] as 9-bit. It is zero-extended, except k=3 when signed, where it is sign-extended.
  - acc += sext64(rm_ext * chunk_k) << 8k, mod 2^64.
  - cnt increments each cycle; at cnt=3 go to ACC.
  - Operand inputs are ignored in MUL; latched values are used.
- ACC (1 cycle): cache = acc + {rh, rn} (latched), mod 2^64. Set cache_valid=1, store the tag, go to IDLE.
- Latency: miss at cycle 0 gives o_busy=1 for cycles 0..5. Cycle 6 hits (o_busy=0, o_rd valid) if operands are unchanged.
- If operands changed while busy, the completion at ACC misses at cycle 6 and a new sequence starts. No hang occurs.
- Consecutive low then high requests with identical operands: the second hits immediately with zero stall.
- i_start=0 in IDLE: no state change; the cache is retained.
- Cache is invalidated only by reset and the two clears. A stall never invalidates it.

Test Plan:
- Unsigned: rm=rs=0xFFFFFFFF, rn=rh=0, i_high=0, i_start held. Required: o_busy=1 for exactly 6 cycles, then o_rd=0x00000001. Next op with i_high=1 and the same operands: o_busy=0 same cycle, o_rd=0xFFFFFFFE.
- Signed: rm=0xFFFFFFFF (-1), rs=2, {rh,rn}={0,5}. Required: result 0x00000000_00000003. Separately, rm=rs=0x80000000, acc=0 gives 0x40000000_00000000.
- Stall: assert i_data_stall for 3 cycles at MUL cnt=1. Required: busy window extends to 9 cycles and the result is still 0xFFFFFFFE_00000001 for the first case.
- clear_from_alu at ACC without stall. Required: next cycle IDLE, cache_valid=0, re-issued op takes the full 6-cycle stall.
- Simultaneous i_clear_from_writeback and i_data_stall mid-MUL: clear wins, sequencer goes to IDLE. Simultaneous i_data_stall and i_clear_from_alu: stall wins, state held.
- Reset asserted at MUL cnt=2, released. Required: o_busy follows i_start, o_rd=0, and a fresh op completes correctly in 6 cycles.
